// File: rtl/fp_mul_round_pack.sv
// Normalize, round-to-nearest-even and pack stage behind the fp_multiplier mantissa array.
// Two register stages with a shared advance: results leave in order through a valid/ready port.
module fp_mul_round_pack #(
  parameter int EXP_W = 10,
  parameter int BIAS  = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic [47:0] mant_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);

  logic                    adv;

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_sign_q,  s1_sign_d;
  logic signed [EXP_W-1:0] s1_exp_q,   s1_exp_d;
  logic [23:0]             s1_mant_q,  s1_mant_d;
  logic                    s1_g_q,     s1_g_d;
  logic                    s1_s_q,     s1_s_d;
  logic                    s1_nan_q,   s1_nan_d;
  logic                    s1_inv_q,   s1_inv_d;
  logic                    s1_inf_q,   s1_inf_d;
  logic                    s1_zero_q,  s1_zero_d;

  logic                    out_valid_q, out_valid_d;
  logic [31:0]             result_q,    result_d;
  logic [3:0]              flags_q,     flags_d;

  logic [7:0]              e1, e2;
  logic                    nan1, nan2, inf1, inf2, zero1, zero2;
  logic signed [EXP_W-1:0] exp_base;

  logic                    round_up;
  logic [24:0]             mant_sum;
  logic [23:0]             mant_rnd;
  logic signed [EXP_W-1:0] exp_rnd;
  logic                    inexact;
  logic [31:0]             res_s;
  logic [3:0]              flg_s;

  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // Operand classification and pre-normalization for stage 1
  always_comb begin
    e1       = num1[30:23];
    e2       = num2[30:23];
    nan1     = (e1 == 8'hFF) && (num1[22:0] != 23'h0);
    nan2     = (e2 == 8'hFF) && (num2[22:0] != 23'h0);
    inf1     = (e1 == 8'hFF) && (num1[22:0] == 23'h0);
    inf2     = (e2 == 8'hFF) && (num2[22:0] == 23'h0);
    zero1    = (e1 == 8'h00);
    zero2    = (e2 == 8'h00);
    exp_base = EXP_W'(e1) + EXP_W'(e2) - EXP_W'(BIAS);

    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_g_d     = s1_g_q;
    s1_s_d     = s1_s_q;
    s1_nan_d   = s1_nan_q;
    s1_inv_d   = s1_inv_q;
    s1_inf_d   = s1_inf_q;
    s1_zero_d  = s1_zero_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = num1[31] ^ num2[31];
        s1_nan_d  = nan1 | nan2;
        s1_inv_d  = (inf1 & zero2) | (inf2 & zero1);
        s1_inf_d  = inf1 | inf2;
        s1_zero_d = zero1 | zero2;
        if (mant_prod[47]) begin
          s1_exp_d  = exp_base + EXP_W'(1);
          s1_mant_d = mant_prod[47:24];
          s1_g_d    = mant_prod[23];
          s1_s_d    = |mant_prod[22:0];
        end else begin
          s1_exp_d  = exp_base;
          s1_mant_d = mant_prod[46:23];
          s1_g_d    = mant_prod[22];
          s1_s_d    = |mant_prod[21:0];
        end
      end else begin
        s1_sign_d = s1_sign_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Rounding, range checks and special-case priority for stage 2
  always_comb begin
    round_up = s1_g_q & (s1_s_q | s1_mant_q[0]);
    mant_sum = {1'b0, s1_mant_q} + {24'h0, round_up};
    inexact  = s1_g_q | s1_s_q;
    // A carry out of the rounded mantissa means it became 2.0: renormalize to 1.0.
    if (mant_sum[24]) begin
      mant_rnd = 24'h800000;
      exp_rnd  = s1_exp_q + EXP_W'(1);
    end else begin
      mant_rnd = mant_sum[23:0];
      exp_rnd  = s1_exp_q;
    end

    if (s1_nan_q) begin
      res_s = 32'h7FC00000;
      flg_s = 4'b0000;
    end else if (s1_inv_q) begin
      res_s = 32'h7FC00000;
      flg_s = 4'b1000;
    end else if (s1_inf_q) begin
      res_s = {s1_sign_q, 8'hFF, 23'h0};
      flg_s = 4'b0000;
    end else if (s1_zero_q) begin
      res_s = {s1_sign_q, 31'h0};
      flg_s = 4'b0000;
    end else if (exp_rnd >= EXP_MAX) begin
      res_s = {s1_sign_q, 8'hFF, 23'h0};
      flg_s = 4'b0101;
    end else if (exp_rnd <= EXP_ZERO) begin
      res_s = {s1_sign_q, 31'h0};
      flg_s = 4'b0011;
    end else begin
      res_s = {s1_sign_q, exp_rnd[7:0], mant_rnd[22:0]};
      flg_s = {3'b000, inexact};
    end

    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = res_s;
        flags_d  = flg_s;
      end else begin
        result_d = result_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= EXP_ZERO;
      s1_mant_q   <= 24'h0;
      s1_g_q      <= 1'b0;
      s1_s_q      <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_inv_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 32'h0;
      flags_q     <= 4'h0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_mant_q   <= s1_mant_d;
      s1_g_q      <= s1_g_d;
      s1_s_q      <= s1_s_d;
      s1_nan_q    <= s1_nan_d;
      s1_inv_q    <= s1_inv_d;
      s1_inf_q    <= s1_inf_d;
      s1_zero_q   <= s1_zero_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Scoreboard bench for fp_mul_round_pack: directed vectors push expected {result,flags},
// a monitor pops and compares on every output transfer and checks stall stability.
module tb_fp_mul_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [47:0] mant_prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int          checks = 0;
  int          errors = 0;
  logic [35:0] exp_q[$];

  logic        held_v = 1'b0;
  logic [35:0] held   = 36'h0;

  fp_mul_round_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .mant_prod (mant_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [47:0] p,
                      input logic [31:0] er, input logic [3:0] ef);
    int n = 0;
    @(negedge clk);
    num1      = a;
    num2      = b;
    mant_prod = p;
    in_valid  = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept num1=%h", a);
    end else begin
      exp_q.push_back({er, ef});
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    mant_prod = 48'hxxxxxxxxxxxx;
  endtask

  // Monitor: compare every transfer against the scoreboard and verify held outputs
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_valid", {35'h0, out_valid}, 36'h1);
          chk("hold_data", {result, flags}, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output actual=%h required=none", {result, flags});
          end else begin
            chk("result", {result, flags}, exp_q.pop_front());
          end
          held_v = 1'b0;
        end else if (out_valid) begin
          chk("in_ready_stall", {35'h0, in_ready}, 36'h0);
          held   = {result, flags};
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    num1      = 32'h0;
    num2      = 32'h0;
    mant_prod = 48'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", {35'h0, out_valid}, 36'h0);
    chk("reset_result", {result, flags}, 36'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_in_ready", {35'h0, in_ready}, 36'h1);

    // Latency: accepted on one edge, visible after the second
    send(32'h3F800000, 32'h3F800000, 48'h400000000000, 32'h3F800000, 4'h0);
    idle();
    #1;
    chk("latency_1", {35'h0, out_valid}, 36'h0);
    @(negedge clk);
    #1;
    chk("latency_2", {35'h0, out_valid}, 36'h1);

    send(32'h3FC00000, 32'h3FC00000, 48'h900000000000, 32'h40100000, 4'h0);
    send(32'h3F800000, 32'h3F800000, 48'h400000400000, 32'h3F800000, 4'h1);
    send(32'h3F800000, 32'h3F800000, 48'h400000C00000, 32'h3F800002, 4'h1);
    send(32'h3F800000, 32'h3F800000, 48'h400000400001, 32'h3F800001, 4'h1);
    send(32'h3F800000, 32'h3F800000, 48'h7FFFFFC00000, 32'h40000000, 4'h1);
    send(32'h7F000000, 32'h7F000000, 48'h400000000000, 32'h7F800000, 4'h5);
    send(32'h7F000000, 32'h3F800000, 48'h7FFFFFC00000, 32'h7F800000, 4'h5);
    send(32'h0D800000, 32'h0D800000, 48'h400000000000, 32'h00000000, 4'h3);
    send(32'h00800000, 32'h3F800000, 48'h400000000000, 32'h00800000, 4'h0);
    send(32'h00800000, 32'h3F000000, 48'h400000000000, 32'h00000000, 4'h3);
    send(32'h7F800000, 32'h00000000, 48'h000000000000, 32'h7FC00000, 4'h8);
    send(32'h7FC00001, 32'h3F800000, 48'h400000000000, 32'h7FC00000, 4'h0);
    send(32'hFF800000, 32'h40000000, 48'h400000000000, 32'hFF800000, 4'h0);
    send(32'h00000001, 32'h3F800000, 48'h400000000000, 32'h00000000, 4'h0);
    send(32'h80000000, 32'h3F800000, 48'h400000000000, 32'h80000000, 4'h0);
    send(32'hBFC00000, 32'h3FC00000, 48'h900000000000, 32'hC0100000, 4'h0);
    idle();
    repeat (4) @(negedge clk);

    // Back-to-back stream with a three-cycle consumer stall
    fork
      begin
        send(32'h3FC00000, 32'h3FC00000, 48'h900000000000, 32'h40100000, 4'h0);
        send(32'h3F800000, 32'h3F800000, 48'h400000000000, 32'h3F800000, 4'h0);
        send(32'hBFC00000, 32'h3FC00000, 48'h900000000000, 32'hC0100000, 4'h0);
        send(32'h3F800000, 32'h3F800000, 48'h400000C00000, 32'h3F800002, 4'h1);
        idle();
      end
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);

    // Reset with two ops in flight: nothing stale may come out afterwards
    out_ready = 1'b0;
    send(32'h3FC00000, 32'h3FC00000, 48'h900000000000, 32'h40100000, 4'h0);
    send(32'h3F800000, 32'h3F800000, 48'h400000000000, 32'h3F800000, 4'h0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("midreset_out_valid", {35'h0, out_valid}, 36'h0);
    chk("midreset_result", {result, flags}, 36'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("midreset_in_ready", {35'h0, in_ready}, 36'h1);
    repeat (5) @(negedge clk);

    send(32'h40000000, 32'h40000000, 48'h400000000000, 32'h40800000, 4'h0);
    idle();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
